// File: rtl/metaframe_pkg.sv
// rtl/metaframe_pkg.sv - shared encodings and default words for the metaframe TX controller
package metaframe_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SYNC,
    ST_SCRAM,
    ST_SKIP,
    ST_PAYLOAD,
    ST_DIAG
  } mf_state_e;

  localparam logic [5:0]  SCRAM_PREFIX = 6'b001010;
  localparam logic [5:0]  DIAG_PREFIX  = 6'b011001;
  localparam logic [1:0]  HDR_DATA     = 2'b01;
  localparam logic [1:0]  HDR_CTRL     = 2'b10;

  localparam logic [63:0] DEFAULT_SYNC_WORD = 64'h78f678f678f678f6;
  localparam logic [63:0] DEFAULT_SKIP_WORD = 64'h1e1e1e1e1e1e1e1e;
  localparam logic [63:0] DEFAULT_IDLE_WORD = 64'h0300000000000000;

endpackage

// File: rtl/metaframe_tx_ctrl.sv
// rtl/metaframe_tx_ctrl.sv - metaframe builder feeding the 64b/67b scrambler
module metaframe_tx_ctrl
  import metaframe_pkg::*;
#(
  parameter int          TX_DATA_WIDTH = 64,
  parameter int          METAFRAME_LEN = 2048,
  parameter logic [63:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter logic [63:0] SKIP_WORD     = DEFAULT_SKIP_WORD,
  parameter logic [63:0] IDLE_WORD     = DEFAULT_IDLE_WORD
) (
  input  logic                     USER_CLK,
  input  logic                     SYSTEM_RESET,
  input  logic                     ENABLE,
  input  logic [TX_DATA_WIDTH-1:0] DATA_IN,
  input  logic [1:0]               HEADER_IN,
  input  logic                     DATA_VALID_IN,
  output logic                     DATA_READY_OUT,
  input  logic [1:0]               DIAG_STATUS_IN,
  input  logic [31:0]              DIAG_CRC_IN,
  output logic [TX_DATA_WIDTH-1:0] TX_DATA_OUT,
  output logic [1:0]               TX_HEADER_OUT,
  output logic                     PASSTHROUGH_OUT,
  output logic                     FRAME_START_OUT,
  output logic                     PROTO_ERR_OUT,
  output logic [15:0]              MF_COUNT_OUT
);

  // Slot counter is loaded with (payload slots - 1) and the last slot is at zero.
  localparam logic [15:0] SLOT_INIT = 16'(METAFRAME_LEN - 5);

  mf_state_e                state_q, state_d;
  logic [15:0]              slot_q, slot_d;
  logic [TX_DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]               hdr_q, hdr_d;
  logic                     pass_q, pass_d;
  logic                     fs_q, fs_d;
  logic                     perr_q, perr_d;
  logic [15:0]              cnt_q, cnt_d;

  logic xfer;
  logic forbidden;

  assign DATA_READY_OUT = (state_q == ST_PAYLOAD) && !SYSTEM_RESET;
  assign xfer           = DATA_VALID_IN && DATA_READY_OUT;
  // A raw sync word in the payload would make the scrambler re-lock mid-frame.
  assign forbidden      = (DATA_IN == SYNC_WORD) && (HEADER_IN == HDR_CTRL);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    data_d  = data_q;
    hdr_d   = HDR_CTRL;
    pass_d  = 1'b0;
    fs_d    = 1'b0;
    perr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        data_d = IDLE_WORD;
        pass_d = 1'b1;
        if (ENABLE) begin
          data_d  = SYNC_WORD;
          pass_d  = 1'b0;
          fs_d    = 1'b1;
          state_d = ST_SCRAM;
        end
      end
      ST_SYNC: begin
        data_d  = SYNC_WORD;
        fs_d    = 1'b1;
        state_d = ST_SCRAM;
      end
      ST_SCRAM: begin
        data_d  = {SCRAM_PREFIX, 58'h0};
        state_d = ST_SKIP;
      end
      ST_SKIP: begin
        data_d  = SKIP_WORD;
        slot_d  = SLOT_INIT;
        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (xfer && !forbidden) begin
          data_d = DATA_IN;
          hdr_d  = HEADER_IN;
        end else begin
          data_d = IDLE_WORD;
        end
        perr_d = xfer && forbidden;
        if (slot_q == 16'd0) begin
          state_d = ST_DIAG;
        end else begin
          slot_d = slot_q - 16'd1;
        end
      end
      ST_DIAG: begin
        data_d  = {DIAG_PREFIX, 24'h0, DIAG_STATUS_IN, DIAG_CRC_IN};
        cnt_d   = cnt_q + 16'd1;
        state_d = ENABLE ? ST_SYNC : ST_OFF;
      end
      default: begin
        data_d  = IDLE_WORD;
        pass_d  = 1'b1;
        state_d = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state_q <= ST_OFF;
      slot_q  <= 16'd0;
      data_q  <= '0;
      hdr_q   <= HDR_DATA;
      pass_q  <= 1'b1;
      fs_q    <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      pass_q  <= pass_d;
      fs_q    <= fs_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign TX_DATA_OUT     = data_q;
  assign TX_HEADER_OUT   = hdr_q;
  assign PASSTHROUGH_OUT = pass_q;
  assign FRAME_START_OUT = fs_q;
  assign PROTO_ERR_OUT   = perr_q;
  assign MF_COUNT_OUT    = cnt_q;

endmodule

// File: tb/tb_metaframe_tx_ctrl.sv
// tb/tb_metaframe_tx_ctrl.sv - scoreboard bench for metaframe_tx_ctrl with METAFRAME_LEN=8
module tb_metaframe_tx_ctrl;

  localparam int          LEN  = 8;
  localparam logic [63:0] SYNC = 64'h78f678f678f678f6;
  localparam logic [63:0] SKIP = 64'h1e1e1e1e1e1e1e1e;
  localparam logic [63:0] IDLE = 64'h0300000000000000;

  logic        clk = 1'b0;
  logic        rst, en, valid, rdy;
  logic [63:0] din, dout;
  logic [1:0]  hin, hout, st;
  logic [31:0] crc;
  logic        pass, fs, perr;
  logic [15:0] mfc;

  metaframe_tx_ctrl #(.METAFRAME_LEN(LEN)) dut (
    .USER_CLK(clk), .SYSTEM_RESET(rst), .ENABLE(en), .DATA_IN(din), .HEADER_IN(hin),
    .DATA_VALID_IN(valid), .DATA_READY_OUT(rdy), .DIAG_STATUS_IN(st), .DIAG_CRC_IN(crc),
    .TX_DATA_OUT(dout), .TX_HEADER_OUT(hout), .PASSTHROUGH_OUT(pass),
    .FRAME_START_OUT(fs), .PROTO_ERR_OUT(perr), .MF_COUNT_OUT(mfc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  h;
    logic        p;
    logic        fs;
    logic        pe;
    logic [15:0] c;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] pay_q[$];
  int          checks = 0;
  int          errors = 0;

  // Bench model: mpos is the index of the next word to emit within the frame.
  bit          mrun = 1'b0;
  int          mpos = 0;
  logic [15:0] mcnt = 16'd0;

  bit          scr_on = 1'b0;
  bit          scr_first;
  logic [57:0] scr_s, dsc_s;

  task automatic scramble(input logic [63:0] d, input logic [57:0] s,
                          output logic [63:0] o, output logic [57:0] so);
    so = s;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ so[38] ^ so[57];
      so   = {so[56:0], o[i]};
    end
  endtask

  task automatic descramble(input logic [63:0] c, input logic [57:0] s,
                            output logic [63:0] o, output logic [57:0] so);
    so = s;
    for (int i = 0; i < 64; i++) begin
      o[i] = c[i] ^ so[38] ^ so[57];
      so   = {so[56:0], c[i]};
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic v,
                       input logic [63:0] d, input logic [1:0] h, output logic xfer);
    exp_t        x, got;
    logic        rdy_exp;
    logic [63:0] c, rec;
    rst = r; en = e; valid = v; din = d; hin = h;
    st  = 2'($urandom_range(0, 3));
    crc = $urandom;
    rdy_exp = !r && mrun && (mpos >= 3) && (mpos <= LEN - 2);
    xfer    = v && rdy_exp;
    x = '{d: IDLE, h: 2'b10, p: 1'b0, fs: 1'b0, pe: 1'b0, c: mcnt};
    if (r) begin
      x = '{d: 64'h0, h: 2'b01, p: 1'b1, fs: 1'b0, pe: 1'b0, c: 16'd0};
      mrun = 1'b0; mpos = 0; mcnt = 16'd0;
    end else if (!mrun) begin
      if (e) begin
        x.d = SYNC; x.fs = 1'b1; mrun = 1'b1; mpos = 1;
      end else begin
        x.p = 1'b1;
      end
    end else begin
      if (mpos == 0) begin
        x.d = SYNC; x.fs = 1'b1;
      end else if (mpos == 1) begin
        x.d = {6'b001010, 58'h0};
      end else if (mpos == 2) begin
        x.d = SKIP;
      end else if (mpos == LEN - 1) begin
        mcnt = mcnt + 16'd1;
        x.c  = mcnt;
        x.d  = {6'b011001, 24'h0, st, crc};
      end else if (xfer) begin
        if (d == SYNC && h == 2'b10) begin
          x.pe = 1'b1;
        end else begin
          x.d = d; x.h = h;
          if (scr_on) pay_q.push_back(d);
        end
      end
      if (mpos == LEN - 1) begin
        if (e) mpos = 0;
        else mrun = 1'b0;
      end else begin
        mpos++;
      end
    end
    exp_q.push_back(x);

    @(negedge clk);
    checks++;
    if (rdy !== rdy_exp) begin
      errors++;
      $display("FAIL ready: got %b expected %b (mpos %0d)", rdy, rdy_exp, mpos);
    end

    @(posedge clk);
    #1;
    got = '{d: dout, h: hout, p: pass, fs: fs, pe: perr, c: mfc};
    x = exp_q.pop_front();
    checks++;
    if (got !== x) begin
      errors++;
      $display("FAIL output: got d=%h h=%b p=%b fs=%b pe=%b c=%0d expected d=%h h=%b p=%b fs=%b pe=%b c=%0d",
               got.d, got.h, got.p, got.fs, got.pe, got.c, x.d, x.h, x.p, x.fs, x.pe, x.c);
    end

    if (scr_on && !pass) begin
      scramble(dout, scr_s, c, scr_s);
      if (scr_first) begin
        dsc_s = {$urandom, 26'($urandom)};
      end
      descramble(c, dsc_s, rec, dsc_s);
      if (!scr_first && hout == 2'b01) begin
        checks++;
        if (pay_q.size() == 0) begin
          errors++;
          $display("FAIL descram: got %h with no payload expected", rec);
        end else if (rec !== pay_q[0]) begin
          errors++;
          $display("FAIL descram: got %h expected %h", rec, pay_q[0]);
          void'(pay_q.pop_front());
        end else begin
          void'(pay_q.pop_front());
        end
      end
      scr_first = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic x;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0, 2'b01, x);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, 2'b01, x);
  endtask

  task automatic test_idle_frames();
    logic x;
    for (int i = 0; i < 3 * LEN; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 2'b01, x);
  endtask

  task automatic test_payload();
    logic        x;
    logic [63:0] p = 64'd1;
    for (int i = 0; i < 3 * LEN; i++) begin
      cycle(1'b0, 1'b1, 1'b1, p, 2'b01, x);
      if (x) p++;
    end
  endtask

  task automatic test_forbidden();
    logic x;
    int   g = 0;
    while (!(mrun && mpos == 4) && g < 4 * LEN) begin
      cycle(1'b0, 1'b1, 1'b1, 64'h100 + 64'(g), 2'b01, x);
      g++;
    end
    cycle(1'b0, 1'b1, 1'b1, SYNC, 2'b10, x);
    cycle(1'b0, 1'b1, 1'b1, 64'h55aa, 2'b01, x);
    for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 1'b1, 64'h200 + 64'(i), 2'b10, x);
  endtask

  task automatic test_enable_drop();
    logic x;
    int   g = 0;
    while (!(mrun && mpos == 5) && g < 4 * LEN) begin
      cycle(1'b0, 1'b1, 1'b1, 64'h300 + 64'(g), 2'b01, x);
      g++;
    end
    for (int i = 0; i < LEN + 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'h400 + 64'(i), 2'b01, x);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 2'b01, x);
  endtask

  task automatic test_reset_mid();
    logic x;
    int   g = 0;
    while (!(mrun && mpos == 2) && g < 4 * LEN) begin
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 2'b01, x);
      g++;
    end
    cycle(1'b1, 1'b1, 1'b1, 64'h0, 2'b01, x);
    for (int i = 0; i < LEN; i++) cycle(1'b0, 1'b1, 1'b1, 64'h500 + 64'(i), 2'b01, x);
  endtask

  task automatic test_scrambler();
    logic        x;
    logic [63:0] p = 64'hdead_0000_0000_0001;
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 2'b01, x);
    scr_on    = 1'b1;
    scr_first = 1'b1;
    scr_s     = 58'h0;
    for (int i = 0; i < 3 * LEN + 1; i++) begin
      cycle(1'b0, 1'b1, 1'b1, p, 2'b01, x);
      if (x) p = p * 64'd6364136223846793005 + 64'd1442695040888963407;
    end
    scr_on = 1'b0;
    checks++;
    if (pay_q.size() != 0) begin
      errors++;
      $display("FAIL descram_left: got %0d words undelivered expected 0", pay_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; din = '0; hin = 2'b01; st = '0; crc = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_idle_frames();
    test_payload();
    test_forbidden();
    test_enable_drop();
    test_reset_mid();
    test_scrambler();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
